// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared definitions for the single-clock FIFO controller.
// Read-mode encodings, default thresholds and the per-cycle op type.
package sync_fifo_ctrl_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  localparam int DEF_AEMPTY_TH = 2;

  function automatic int def_afull_th(input int asize);
    return (1 << asize) - 2;
  endfunction

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

endpackage

// File: rtl/sync_fifo_mem.sv
// Dual-port storage array for the FIFO.
// One write port; read port registered (REG_OUT=1) or asynchronous.
module sync_fifo_mem
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int DSIZE   = 32,
  parameter int ASIZE   = 5,
  parameter int REG_OUT = 1
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_we,
  input  logic [ASIZE-1:0] i_waddr,
  input  logic [DSIZE-1:0] i_wdata,
  input  logic             i_re,
  input  logic [ASIZE-1:0] i_raddr,
  output logic [DSIZE-1:0] o_rdata
);

  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg
      logic [DSIZE-1:0] r_rdata;

      always_ff @(posedge clk) begin
        if (i_clr) begin
          r_rdata <= '0;
        end else if (i_re) begin
          r_rdata <= r_mem[i_raddr];
        end
      end

      assign o_rdata = r_rdata;
    end else begin : g_async
      logic w_unused;
      assign w_unused = &{1'b0, i_clr, i_re};
      assign o_rdata  = r_mem[i_raddr];
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: pointers, occupancy, threshold flags,
// sticky error flags and flush/reset handling around sync_fifo_mem.
module sync_fifo_ctrl
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int DSIZE     = 32,
  parameter int ASIZE     = 5,
  parameter int FWFT      = FIFO_MODE_STD,
  parameter int AFULL_TH  = def_afull_th(ASIZE),
  parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << ASIZE;

  localparam logic [ASIZE:0] DEPTH_C = {1'b1, {ASIZE{1'b0}}};
  localparam logic [ASIZE:0] AF_C    = AFULL_TH[ASIZE:0];
  localparam logic [ASIZE:0] AE_C    = AEMPTY_TH[ASIZE:0];

  generate
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
      $error("sync_fifo_ctrl: AFULL_TH out of range");
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
      $error("sync_fifo_ctrl: AEMPTY_TH out of range");
    end
  endgenerate

  logic [ASIZE:0]   r_wptr;
  logic [ASIZE:0]   r_rptr;
  logic [ASIZE:0]   r_count;
  logic             r_ovf;
  logic             r_udf;

  logic             w_full;
  logic             w_empty;
  logic             w_wr;
  logic             w_rd;
  logic             w_clr;
  op_e              w_op;
  logic [ASIZE:0]   w_count_nxt;
  logic [DSIZE-1:0] w_mem_rdata;

  // Flags come only from the registered count, never from winc/rinc.
  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);

  assign w_wr  = winc & ~w_full & ~flush;
  assign w_rd  = rinc & ~w_empty & ~flush;
  assign w_clr = rst | flush;
  assign w_op  = op_e'({w_rd, w_wr});

  always_comb begin
    w_count_nxt = r_count;
    unique case (w_op)
      OP_WR:   w_count_nxt = r_count + 1'b1;
      OP_RD:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= w_count_nxt;
    end
  end

  // Error flags survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (!flush) begin
      if (winc && w_full) begin
        r_ovf <= 1'b1;
      end
      if (rinc && w_empty) begin
        r_udf <= 1'b1;
      end
    end
  end

  sync_fifo_mem #(
    .DSIZE   (DSIZE),
    .ASIZE   (ASIZE),
    .REG_OUT ((FWFT == FIFO_MODE_FWFT) ? 0 : 1)
  ) u_mem (
    .clk     (clk),
    .i_clr   (w_clr),
    .i_we    (w_wr),
    .i_waddr (r_wptr[ASIZE-1:0]),
    .i_wdata (wdata),
    .i_re    (w_rd),
    .i_raddr (r_rptr[ASIZE-1:0]),
    .o_rdata (w_mem_rdata)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign rdata = w_empty ? '0 : w_mem_rdata;
    end else begin : g_std
      assign rdata = w_mem_rdata;
    end
  endgenerate

  assign wfull         = w_full;
  assign rempty        = w_empty;
  assign walmost_full  = (r_count >= AF_C);
  assign ralmost_empty = (r_count <= AE_C);
  assign count         = r_count;
  assign overflow      = r_ovf;
  assign underflow     = r_udf;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: standard-mode and
// fall-through instances driven from the same stimulus.
module tb_sync_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] wdata = '0;
  logic       winc = 1'b0;
  logic       rinc = 1'b0;

  logic       wfull0, wafull0, rempty0, raempty0, ovf0, udf0;
  logic [7:0] rdata0;
  logic [2:0] count0;
  logic       wfull1, wafull1, rempty1, raempty1, ovf1, udf1;
  logic [7:0] rdata1;
  logic [2:0] count1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(
    .DSIZE(8), .ASIZE(2), .FWFT(0), .AFULL_TH(3), .AEMPTY_TH(1)
  ) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .wdata(wdata), .winc(winc),
    .wfull(wfull0), .walmost_full(wafull0), .rinc(rinc), .rdata(rdata0),
    .rempty(rempty0), .ralmost_empty(raempty0), .count(count0),
    .overflow(ovf0), .underflow(udf0)
  );

  sync_fifo_ctrl #(
    .DSIZE(8), .ASIZE(2), .FWFT(1), .AFULL_TH(3), .AEMPTY_TH(1)
  ) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .wdata(wdata), .winc(winc),
    .wfull(wfull1), .walmost_full(wafull1), .rinc(rinc), .rdata(rdata1),
    .rempty(rempty1), .ralmost_empty(raempty1), .count(count1),
    .overflow(ovf1), .underflow(udf1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    winc = 0; rinc = 0; flush = 0;
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    logic [9:0] got0, got1;
    logic [9:0] exp;
    do_reset();
    exp  = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    got0 = {rempty0, raempty0, wfull0, wafull0, ovf0, udf0, count0,
            |rdata0};
    got1 = {rempty1, raempty1, wfull1, wafull1, ovf1, udf1, count1,
            |rdata1};
    total++;
    if (got0 !== exp)
      $display("FAIL reset_std flags got=%b exp=%b", got0, exp);
    else passed++;
    total++;
    if (got1 !== exp)
      $display("FAIL reset_fwft flags got=%b exp=%b", got1, exp);
    else passed++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      wdata = 8'hA1 + 8'(i);
      winc  = 1;
      tick();
      winc  = 0;
      total++;
      if (count0 !== 3'(i + 1) || wafull0 !== (i >= 2) ||
          wfull0 !== (i == 3))
        $display("FAIL fill_%0d count=%0d af=%b f=%b exp_count=%0d",
                 i, count0, wafull0, wfull0, i + 1);
      else passed++;
    end
    wdata = 8'hA5;
    winc  = 1;
    tick();
    winc  = 0;
    total++;
    if (ovf0 !== 1'b1 || count0 !== 3'd4)
      $display("FAIL overflow ovf=%b count=%0d exp ovf=1 count=4",
               ovf0, count0);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      rinc = 1;
      tick();
      rinc = 0;
      total++;
      if (rdata0 !== 8'hA1 + 8'(i) || count0 !== 3'(3 - i) ||
          raempty0 !== (i >= 2))
        $display("FAIL drain_%0d rdata=%h count=%0d ae=%b exp=%h",
                 i, rdata0, count0, raempty0, 8'hA1 + 8'(i));
      else passed++;
    end
  endtask

  task automatic test_empty_read();
    rinc = 1;
    tick();
    rinc = 0;
    total++;
    if (udf0 !== 1'b1 || count0 !== 3'd0 || rdata0 !== 8'hA4)
      $display("FAIL empty_read udf=%b count=%0d rdata=%h exp 1/0/a4",
               udf0, count0, rdata0);
    else passed++;
    tick();
    tick();
    total++;
    if (udf0 !== 1'b1 || rempty0 !== 1'b1)
      $display("FAIL udf_sticky udf=%b rempty=%b exp 1/1", udf0, rempty0);
    else passed++;
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_q [3];
    do_reset();
    for (int i = 0; i < 2; i++) begin
      wdata = 8'hB1 + 8'(i);
      winc  = 1;
      tick();
    end
    wdata = 8'hB3;
    rinc  = 1;
    tick();
    rinc  = 0;
    total++;
    if (count0 !== 3'd2 || rdata0 !== 8'hB1)
      $display("FAIL simul_mid count=%0d rdata=%h exp 2/b1",
               count0, rdata0);
    else passed++;
    wdata = 8'hB4; tick();
    wdata = 8'hB5; tick();
    total++;
    if (wfull0 !== 1'b1 || ovf0 !== 1'b0)
      $display("FAIL simul_full_pre wfull=%b ovf=%b exp 1/0",
               wfull0, ovf0);
    else passed++;
    wdata = 8'hC0;
    rinc  = 1;
    tick();
    winc  = 0;
    rinc  = 0;
    total++;
    if (count0 !== 3'd3 || ovf0 !== 1'b1 || rdata0 !== 8'hB2)
      $display("FAIL simul_full count=%0d ovf=%b rdata=%h exp 3/1/b2",
               count0, ovf0, rdata0);
    else passed++;
    exp_q = '{8'hB3, 8'hB4, 8'hB5};
    for (int i = 0; i < 3; i++) begin
      rinc = 1;
      tick();
      rinc = 0;
      total++;
      if (rdata0 !== exp_q[i])
        $display("FAIL simul_drain_%0d rdata=%h exp=%h",
                 i, rdata0, exp_q[i]);
      else passed++;
    end
    wdata = 8'hD0;
    winc  = 1;
    rinc  = 1;
    tick();
    winc  = 0;
    rinc  = 0;
    total++;
    if (count0 !== 3'd1 || udf0 !== 1'b1 || rdata0 !== 8'hB5)
      $display("FAIL simul_empty count=%0d udf=%b rdata=%h exp 1/1/b5",
               count0, udf0, rdata0);
    else passed++;
    rinc = 1;
    tick();
    rinc = 0;
    total++;
    if (rdata0 !== 8'hD0 || count0 !== 3'd0)
      $display("FAIL simul_empty_pop rdata=%h count=%0d exp d0/0",
               rdata0, count0);
    else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    winc = 1;
    wdata = 8'h00; tick();
    wdata = 8'h01; tick();
    rinc = 1;
    for (int i = 0; i < 8; i++) begin
      wdata = 8'(i + 2);
      tick();
      total++;
      if (rdata0 !== 8'(i) || count0 !== 3'd2)
        $display("FAIL wrap_%0d rdata=%h count=%0d exp=%h",
                 i, rdata0, count0, 8'(i));
      else passed++;
    end
    winc = 0;
    for (int i = 8; i < 10; i++) begin
      tick();
      total++;
      if (rdata0 !== 8'(i))
        $display("FAIL wrap_tail_%0d rdata=%h exp=%h", i, rdata0, 8'(i));
      else passed++;
    end
    rinc = 0;
    total++;
    if (rempty0 !== 1'b1 || udf0 !== 1'b0)
      $display("FAIL wrap_end rempty=%b udf=%b exp 1/0", rempty0, udf0);
    else passed++;
  endtask

  task automatic test_fwft_flush();
    do_reset();
    wdata = 8'h5C;
    winc  = 1;
    tick();
    winc  = 0;
    total++;
    if (rempty1 !== 1'b0 || rdata1 !== 8'h5C)
      $display("FAIL fwft_show rempty=%b rdata=%h exp 0/5c",
               rempty1, rdata1);
    else passed++;
    rinc = 1;
    tick();
    total++;
    if (rempty1 !== 1'b1 || rdata1 !== 8'h00 || rdata0 !== 8'h5C)
      $display("FAIL fwft_pop rempty=%b rdata=%h std=%h exp 1/00/5c",
               rempty1, rdata1, rdata0);
    else passed++;
    tick();
    rinc = 0;
    total++;
    if (udf1 !== 1'b1)
      $display("FAIL fwft_udf udf=%b exp 1", udf1);
    else passed++;
    winc = 1;
    for (int i = 0; i < 3; i++) begin
      wdata = 8'h60 + 8'(i);
      tick();
    end
    total++;
    if (count1 !== 3'd3 || rdata1 !== 8'h60)
      $display("FAIL fwft_fill count=%0d rdata=%h exp 3/60",
               count1, rdata1);
    else passed++;
    flush = 1;
    wdata = 8'h77;
    tick();
    flush = 0;
    winc  = 0;
    total++;
    if (count1 !== 3'd0 || rempty1 !== 1'b1 || rdata1 !== 8'h00 ||
        udf1 !== 1'b1)
      $display("FAIL fwft_flush count=%0d rempty=%b rdata=%h udf=%b",
               count1, rempty1, rdata1, udf1);
    else passed++;
    total++;
    if (count0 !== 3'd0 || rdata0 !== 8'h00 || udf0 !== 1'b1)
      $display("FAIL std_flush count=%0d rdata=%h udf=%b exp 0/00/1",
               count0, rdata0, udf0);
    else passed++;
    winc  = 1;
    wdata = 8'h88;
    tick();
    winc  = 0;
    total++;
    if (rdata1 !== 8'h88 || count1 !== 3'd1)
      $display("FAIL post_flush rdata=%h count=%0d exp 88/1",
               rdata1, count1);
    else passed++;
  endtask

  initial begin
    tick();
    test_reset();
    test_fill();
    test_empty_read();
    test_simultaneous();
    test_wrap();
    test_fwft_flush();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
